corefifo_wr_ptr_ctrl: RTL and testbench
=======================================

// Module: corefifo_wr_ptr_ctrl
// PURPOSE
//  Write-side pointer and flag controller for the ADC sample FIFO.
//  - Keeps the binary and Gray write pointers, and gates RAM writes.
//  - Synchronises the read-domain Gray pointer into this clock, then converts it to binary.
//  - Produces full, almost-full, fill count and overflow.
//  - Its wptr_gray output feeds the read-side synchroniser and Gray-to-binary stage.
// PARAMETERS
//  ADDRWIDTH    3  RAM address bits; pointers are ADDRWIDTH+1 bits; DEPTH = 2**ADDRWIDTH
//  AFULL_VAL    6  afull asserts when the fill count is >= AFULL_VAL (1..DEPTH)
//  SYNC_STAGES  2  flop stages on rptr_gray_in (>=2)
// PORTS
//  clk          in   1            write-domain clock, rising edge
//  reset        in   1            asynchronous, active-high reset
//  we           in   1            write request
//  rptr_gray_in in   ADDRWIDTH+1  read pointer (Gray), asynchronous to clk
//  wen_ram      out  1            RAM write enable = we & ~full (combinational)
//  waddr        out  ADDRWIDTH    RAM write address = wptr_bin[ADDRWIDTH-1:0]
//  wptr_gray    out  ADDRWIDTH+1  registered Gray write pointer, sent to the read domain
//  full         out  1            registered full flag
//  afull        out  1            registered almost-full flag
//  wrcnt        out  ADDRWIDTH+1  registered fill count, 0..DEPTH
//  overflow     out  1            1-cycle pulse on a write attempt while full
// BEHAVIOUR
//  - Reset (async assert, sync release): all of the following clear to 0:
//    wptr_bin, wptr_gray, the sync chain, full, afull, wrcnt and overflow.
//  - Accept condition: acc = we & ~full. Write data lands in the RAM at waddr on the same edge.
//  - Pointer update:
//    wptr_bin_nxt = wptr_bin + acc (mod 2**(ADDRWIDTH+1)).
//    wptr_gray <= wptr_bin_nxt ^ (wptr_bin_nxt >> 1).
//    Exactly one bit of wptr_gray changes per accept.
//  - Read pointer path:
//    rptr_gray_in passes through SYNC_STAGES flops, then a combinational Gray->binary stage, giving rptr_bin.
//  - Count and flags (all registered):
//    cnt_nxt = wptr_bin_nxt - rptr_bin (mod 2**(ADDRWIDTH+1)).
//    wrcnt <= cnt_nxt.
//    full  <= (cnt_nxt == DEPTH).
//    afull <= (cnt_nxt >= AFULL_VAL).
//    overflow <= we & full.
//  - Latency:
//    accepted write -> wptr_gray, wrcnt and full update at the next edge (1 cycle).
//    rptr_gray_in change -> flags update SYNC_STAGES+1 edges later.
//  - Full:
//    further writes are blocked; wptr holds; overflow pulses once per blocked cycle.
//    Full is pessimistic: it deasserts only after the read pointer has been synchronised.
//  - Wrap-around:
//    the pointer rolls from 2**(ADDRWIDTH+1)-1 to 0 with a single Gray bit flip (A=3: 1000 -> 0000).
//    The modulo count stays correct across the wrap.
//  - Simultaneous read advance and write:
//    both pointer deltas feed cnt_nxt in the same cycle, so the count holds.
//  - Reset mid-operation:
//    outputs clear immediately, independent of clk.
//    The read side must also be reset, because the FIFO contents are discarded.
//  - Empty never applies on this side; wrcnt == 0 is a legal steady state.
// STRUCTURE
//  - Shared package corefifo_pkg holds:
//    the DEPTH/PTRW localparam derivation, a bin2gray function, and the default AFULL_VAL.
//  - Sub-module: one instance of ADCFIFO_ADCFIFO_0_corefifo_grayToBinConv (ADDRWIDTH passed through).
//    It sits on the synchronised read pointer.
//  - The sync chain is inline: a generate loop of SYNC_STAGES flops, with no logic between the stages.
// TESTING
//  1) Fill: ADDRWIDTH=3, rptr_gray_in=0000, 8 back-to-back writes.
//     -> waddr 0..7; wrcnt 1..8; afull after write 6; full after write 8; wptr_gray=1100.
//  2) Overflow: while full, we=1 for 3 cycles.
//     -> wen_ram=0; wptr_gray stays 1100; overflow=1 for 3 cycles then 0.
//  3) Drain release: rptr_gray_in 0000->0001 while full.
//     -> full=0 and wrcnt=7 exactly SYNC_STAGES+1 edges later; the next write is accepted.
//  4) Wrap: reader tracks 1 behind; 20 writes.
//     -> wptr_gray 1000 -> 0000 on the 16th write; wrcnt holds at 1; no false full.
//  5) Async reset: assert reset mid-burst, between clock edges.
//     -> all outputs 0 before the next edge; the first write after release uses waddr=0.
//  6) Simultaneous: wrcnt=4; write accepted on the same edge the synced rptr advances by 1.
//     -> wrcnt stays 4; full=0; afull=0.

Source files
------------

// File: rtl/corefifo_pkg.sv
// Shared definitions for the ADC sample FIFO: pointer geometry helpers,
// parameter defaults and the binary-to-Gray encoder.
package corefifo_pkg;

  localparam int unsigned ADDRWIDTH_DEF   = 3;
  localparam int unsigned AFULL_VAL_DEF   = 6;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int unsigned ptrw_of(input int unsigned addrwidth);
    return addrwidth + 32'd1;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addrwidth);
    return 32'd1 << addrwidth;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/corefifo_wr_ptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter used on the synchronised read pointer.
module ADCFIFO_ADCFIFO_0_corefifo_grayToBinConv #(
  parameter int unsigned ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH:0] gray_i,
  output logic [ADDRWIDTH:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i <= int'(ADDRWIDTH); i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-side pointer/flag controller: binary and Gray write pointers, RAM write
// gating, read-pointer synchronisation, fill count, full/almost-full and overflow.
module corefifo_wr_ptr_ctrl
  import corefifo_pkg::*;
#(
  parameter int unsigned ADDRWIDTH   = ADDRWIDTH_DEF,
  parameter int unsigned AFULL_VAL   = AFULL_VAL_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rptr_gray_in,
  output logic                 wen_ram,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wrcnt,
  output logic                 overflow
);

  localparam int unsigned PTRW  = ptrw_of(ADDRWIDTH);
  localparam int unsigned DEPTH = depth_of(ADDRWIDTH);

  logic [PTRW-1:0] wptr_bin_q,  wptr_bin_d;
  logic [PTRW-1:0] wptr_gray_q, wptr_gray_d;
  logic [PTRW-1:0] wrcnt_q,     wrcnt_d;
  logic            full_q,      full_d;
  logic            afull_q,     afull_d;
  logic            overflow_q,  overflow_d;
  logic            acc;
  logic [PTRW-1:0] rptr_gray_sync;
  logic [PTRW-1:0] rptr_bin;

  // Read-pointer synchroniser: plain flop chain, nothing between stages.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    logic [PTRW-1:0] q;
    if (s == 0) begin : g_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= rptr_gray_in;
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= g_sync[s-1].q;
      end
    end
  end

  assign rptr_gray_sync = g_sync[SYNC_STAGES-1].q;

  ADCFIFO_ADCFIFO_0_corefifo_grayToBinConv #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_rptr_g2b (
    .gray_i (rptr_gray_sync),
    .bin_o  (rptr_bin)
  );

  // Both pointer deltas land in the same next-count, so a simultaneous
  // write and read advance leaves the count unchanged.
  always_comb begin
    acc         = we & ~full_q;
    wptr_bin_d  = wptr_bin_q + PTRW'(acc);
    wptr_gray_d = PTRW'(bin2gray(32'(wptr_bin_d)));
    wrcnt_d     = wptr_bin_d - rptr_bin;
    full_d      = (wrcnt_d == PTRW'(DEPTH));
    afull_d     = (wrcnt_d >= PTRW'(AFULL_VAL));
    overflow_d  = we & full_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      wrcnt_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      wrcnt_q     <= wrcnt_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wen_ram   = acc;
  assign waddr     = wptr_bin_q[ADDRWIDTH-1:0];
  assign wptr_gray = wptr_gray_q;
  assign wrcnt     = wrcnt_q;
  assign full      = full_q;
  assign afull     = afull_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// Directed self-checking bench for the FIFO write-side pointer controller.
module tb_corefifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [3:0] rptr_gray_in;
  logic       wen_ram;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       afull;
  logic [3:0] wrcnt;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  corefifo_wr_ptr_ctrl #(
    .ADDRWIDTH   (3),
    .AFULL_VAL   (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .rptr_gray_in (rptr_gray_in),
    .wen_ram      (wen_ram),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .full         (full),
    .afull        (afull),
    .wrcnt        (wrcnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    we           = 1'b0;
    rptr_gray_in = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({wptr_gray, wrcnt, full, afull, overflow, waddr} !== 14'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {wptr_gray, wrcnt, full, afull, overflow, waddr});
    end
  endtask

  task automatic test_fill();
    we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (waddr !== 3'(k) || wen_ram !== 1'b1) begin
        failures++;
        $display("FAIL fill_waddr k=%0d got waddr=%0d wen=%b exp waddr=%0d wen=1", k, waddr, wen_ram, k);
      end
      tick();
      checks++;
      if (wrcnt !== 4'(k + 1) || afull !== (k + 1 >= 6) || full !== (k + 1 == 8)) begin
        failures++;
        $display("FAIL fill_flags k=%0d got cnt=%0d af=%b f=%b exp cnt=%0d af=%b f=%b",
                 k, wrcnt, afull, full, k + 1, (k + 1 >= 6), (k + 1 == 8));
      end
    end
    checks++;
    if (wptr_gray !== 4'b1100) begin
      failures++;
      $display("FAIL fill_gray got=%b exp=1100", wptr_gray);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (wen_ram !== 1'b0) begin
        failures++;
        $display("FAIL ovf_wen k=%0d got=%b exp=0", k, wen_ram);
      end
      tick();
      checks++;
      if (overflow !== 1'b1 || wptr_gray !== 4'b1100) begin
        failures++;
        $display("FAIL ovf_pulse k=%0d got ovf=%b gray=%b exp ovf=1 gray=1100", k, overflow, wptr_gray);
      end
    end
    we = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0 || wrcnt !== 4'd8) begin
      failures++;
      $display("FAIL ovf_end got ovf=%b cnt=%0d exp ovf=0 cnt=8", overflow, wrcnt);
    end
  endtask

  task automatic test_drain();
    rptr_gray_in = 4'b0001;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (full !== 1'b1) begin
        failures++;
        $display("FAIL drain_hold edge=%0d got full=%b exp=1", k, full);
      end
    end
    tick();
    checks++;
    if (full !== 1'b0 || wrcnt !== 4'd7 || afull !== 1'b1) begin
      failures++;
      $display("FAIL drain_release got f=%b cnt=%0d af=%b exp f=0 cnt=7 af=1", full, wrcnt, afull);
    end
    we = 1'b1;
    #1;
    checks++;
    if (wen_ram !== 1'b1 || waddr !== 3'd0) begin
      failures++;
      $display("FAIL drain_accept got wen=%b waddr=%0d exp wen=1 waddr=0", wen_ram, waddr);
    end
    tick();
    we = 1'b0;
    checks++;
    if (wrcnt !== 4'd8 || full !== 1'b1 || wptr_gray !== 4'b1101) begin
      failures++;
      $display("FAIL drain_refill got cnt=%0d f=%b gray=%b exp cnt=8 f=1 gray=1101", wrcnt, full, wptr_gray);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wb;
    logic [3:0] wg;
    logic [3:0] rb;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      we = 1'b1;
      tick();
      we = 1'b0;
      wb = 4'(i);
      wg = wb ^ (wb >> 1);
      checks++;
      if (wptr_gray !== wg || wrcnt !== ((i == 1) ? 4'd1 : 4'd2) || full !== 1'b0) begin
        failures++;
        $display("FAIL wrap_write i=%0d got gray=%b cnt=%0d f=%b exp gray=%b cnt=%0d f=0",
                 i, wptr_gray, wrcnt, full, wg, (i == 1) ? 1 : 2);
      end
      if (i == 16) begin
        checks++;
        if (wptr_gray !== 4'b0000) begin
          failures++;
          $display("FAIL wrap_rollover got=%b exp=0000", wptr_gray);
        end
      end
      rb           = 4'(i - 1);
      rptr_gray_in = rb ^ (rb >> 1);
      tick();
      tick();
      tick();
      checks++;
      if (wrcnt !== 4'd1 || full !== 1'b0) begin
        failures++;
        $display("FAIL wrap_settle i=%0d got cnt=%0d f=%b exp cnt=1 f=0", i, wrcnt, full);
      end
    end
  endtask

  task automatic test_async_reset();
    we = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({wptr_gray, wrcnt, full, afull, overflow, waddr} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {wptr_gray, wrcnt, full, afull, overflow, waddr});
    end
    we           = 1'b0;
    rptr_gray_in = 4'b0000;
    tick();
    reset = 1'b0;
    we    = 1'b1;
    #1;
    checks++;
    if (waddr !== 3'd0 || wen_ram !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_addr got waddr=%0d wen=%b exp waddr=0 wen=1", waddr, wen_ram);
    end
    tick();
    checks++;
    if (wrcnt !== 4'd1 || wptr_gray !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_write got cnt=%0d gray=%b exp cnt=1 gray=0001", wrcnt, wptr_gray);
    end
  endtask

  task automatic test_simultaneous();
    tick();
    tick();
    tick();
    we = 1'b0;
    checks++;
    if (wrcnt !== 4'd4) begin
      failures++;
      $display("FAIL simul_setup got cnt=%0d exp=4", wrcnt);
    end
    rptr_gray_in = 4'b0001;
    tick();
    tick();
    we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (wrcnt !== 4'd4 || full !== 1'b0 || afull !== 1'b0 || wptr_gray !== 4'b0111) begin
      failures++;
      $display("FAIL simul_edge got cnt=%0d f=%b af=%b gray=%b exp cnt=4 f=0 af=0 gray=0111",
               wrcnt, full, afull, wptr_gray);
    end
    tick();
    checks++;
    if (wrcnt !== 4'd4) begin
      failures++;
      $display("FAIL simul_hold got cnt=%0d exp=4", wrcnt);
    end
  endtask

  initial begin
    reset        = 1'b1;
    we           = 1'b0;
    rptr_gray_in = 4'b0000;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_async_reset();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
